// File: rtl/demux_seq_pkg.sv
// Shared widths and FSM state encoding for the demux bit sequencer.
package demux_seq_pkg;

   localparam int unsigned NUM_CH = 8;
   localparam int unsigned SEL_W  = 3;
   localparam int unsigned CNT_W  = 8;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = ST_IDLE,
      SHIFT = ST_SHIFT,
      DONE  = ST_DONE
   } state_t;

endpackage

// File: rtl/demux_bit_sequencer_if.sv
// Word handshake plus serial demux drive bundle.
interface demux_bit_sequencer_if;

   logic                                   in_valid;
   logic                                   in_ready;
   logic [demux_seq_pkg::NUM_CH-1:0]       in_word;
   logic [demux_seq_pkg::NUM_CH-1:0]       ch_mask;
   logic                                   data;
   logic [demux_seq_pkg::SEL_W-1:0]        sel;
   logic                                   busy;
   logic                                   done;

   // Upstream producer / downstream observer side
   modport master (
      output in_valid, in_word, ch_mask,
      input  in_ready, data, sel, busy, done
   );

   // Sequencer side
   modport slave (
      input  in_valid, in_word, ch_mask,
      output in_ready, data, sel, busy, done
   );

endinterface

// File: rtl/next_ch_finder.sv
// Combinational search for the lowest enabled channel at or above a start index.
module next_ch_finder
   import demux_seq_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [SEL_W-1:0]  start,
   input  logic              include_start,
   output logic              found,
   output logic [SEL_W-1:0]  idx
);

   // Priority scan from channel 0 upward; first qualifying hit wins
   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!found && mask[i] &&
             ((SEL_W'(i) > start) || (include_start && (SEL_W'(i) == start)))) begin
            found = 1'b1;
            idx   = SEL_W'(i);
         end
      end
   end

endmodule

// File: rtl/demux_bit_sequencer.sv
// Serialises one captured 8-bit word onto data/sel, one enabled channel at a time.
module demux_bit_sequencer
   import demux_seq_pkg::*;
#(
   parameter int unsigned HOLD = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   demux_bit_sequencer_if.slave  bus
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD - 1);

   state_t              r_state, w_state;
   logic [CNT_W-1:0]    r_cnt, w_cnt;
   logic [NUM_CH-1:0]   r_word, w_word;
   logic [NUM_CH-1:0]   r_mask, w_mask;
   logic                r_data, w_data;
   logic [SEL_W-1:0]    r_sel, w_sel;
   logic                r_done, w_done;
   logic                r_busy, w_busy;
   logic                r_in_ready, w_in_ready;

   logic [NUM_CH-1:0]   w_find_mask;
   logic [SEL_W-1:0]    w_find_start;
   logic                w_find_incl;
   logic                w_found;
   logic [SEL_W-1:0]    w_idx;

   // In IDLE search the incoming mask from 0 inclusive; in SHIFT search strictly above sel
   assign w_find_mask  = (r_state == IDLE) ? bus.ch_mask : r_mask;
   assign w_find_start = (r_state == IDLE) ? '0 : r_sel;
   assign w_find_incl  = (r_state == IDLE);

   next_ch_finder u_finder (
      .mask          (w_find_mask),
      .start         (w_find_start),
      .include_start (w_find_incl),
      .found         (w_found),
      .idx           (w_idx)
   );

   // Next-state and next-output logic; data/sel default to 0 outside SHIFT
   always_comb begin
      w_state = r_state;
      w_cnt   = r_cnt;
      w_word  = r_word;
      w_mask  = r_mask;
      w_data  = 1'b0;
      w_sel   = '0;
      w_done  = 1'b0;

      case (r_state)
         IDLE: begin
            if (bus.in_valid) begin
               w_word = bus.in_word;
               w_mask = bus.ch_mask;
               w_cnt  = '0;
               if (w_found) begin
                  w_state = SHIFT;
                  w_sel   = w_idx;
                  w_data  = bus.in_word[w_idx];
               end else begin
                  w_state = DONE;
                  w_done  = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (r_cnt == CNT_LAST) begin
               w_cnt = '0;
               if (w_found) begin
                  w_sel  = w_idx;
                  w_data = r_word[w_idx];
               end else begin
                  w_state = DONE;
                  w_done  = 1'b1;
               end
            end else begin
               w_cnt  = r_cnt + CNT_W'(1);
               w_sel  = r_sel;
               w_data = r_data;
            end
         end
         DONE: begin
            w_state = IDLE;
         end
         default: begin
            w_state = IDLE;
         end
      endcase

      w_busy     = (w_state != IDLE);
      w_in_ready = (w_state == IDLE);
   end

   // State, captured word and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_word     <= '0;
         r_mask     <= '0;
         r_data     <= 1'b0;
         r_sel      <= '0;
         r_done     <= 1'b0;
         r_busy     <= 1'b0;
         r_in_ready <= 1'b1;
      end else begin
         r_state    <= w_state;
         r_cnt      <= w_cnt;
         r_word     <= w_word;
         r_mask     <= w_mask;
         r_data     <= w_data;
         r_sel      <= w_sel;
         r_done     <= w_done;
         r_busy     <= w_busy;
         r_in_ready <= w_in_ready;
      end
   end

   assign bus.in_ready = r_in_ready;
   assign bus.data     = r_data;
   assign bus.sel      = r_sel;
   assign bus.busy     = r_busy;
   assign bus.done     = r_done;

endmodule

// File: doc/demux_bit_sequencer.md
# demux_bit_sequencer

Upstream feeder for the 1-to-8 demux stage. Accepts an 8-bit word over a valid/ready handshake, then drives its bits serially on `data` with the matching channel index on `sel`, one enabled channel at a time. Each enabled bit appears on its own demux output line for a programmable number of cycles. Emits a `done` pulse when the word has been fully distributed.

## Interface
- `HOLD`, default 1: cycles each channel is driven; legal range 1..255.
- `clk`  input  1  sole clock; all state updates on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  upstream word available.
- `in_ready`  output  1  block can accept a word; high only in IDLE.
- `in_word`  input  8  bit i is destined for demux channel i.
- `ch_mask`  input  8  bit i = 1 enables channel i; sampled with `in_word` at accept.
- `data`  output  1  to demux `data`; registered.
- `sel`  output  3  to demux `sel`; registered.
- `busy`  output  1  high in SHIFT and DONE.
- `done`  output  1  one-cycle pulse at end of word.

## Operation
- Accept occurs on a rising edge with `in_valid && in_ready`. The block captures `in_word` and `ch_mask` into internal registers.
- Input changes after accept are ignored until the next IDLE.
- States:
  - IDLE: `in_ready`=1, `data`=0, `sel`=0, `busy`=0.
    - On accept with captured mask nonzero: load `sel` with the lowest enabled index, load `data` with that bit, clear the hold counter, go to SHIFT.
    - On accept with mask 0: go to DONE; no data is driven.
  - SHIFT: hold `sel`/`data` for HOLD cycles, counted 0..HOLD-1.
    - When the count reaches HOLD-1, search for the next enabled index strictly above the current `sel`.
    - If one is found: load it and its bit, reset the count, stay in SHIFT.
    - If none is found: go to DONE, driving `data`=0 and `sel`=0.
    - Channels are never revisited. There is no wrap from 7 to 0 within a word.
  - DONE: exactly one cycle with `done`=1, `busy`=1, `in_ready`=0, `data`=0, `sel`=0. Returns to IDLE.
- Outside SHIFT, `data`=0. The demux's `y` output is therefore all-zero between words.
- A disabled channel is skipped with no idle cycle: the transition from channel a to the next enabled channel b is back-to-back.
- Reset values of all outputs: `in_ready`=1, `data`=0, `sel`=0, `busy`=0, `done`=0. State is IDLE and the counter is 0.
- An assertion of `rst_n` mid-word aborts it immediately:
  - The captured word is discarded.
  - No `done` pulse is produced.
  - Outputs take their reset values asynchronously.

## Timing
- Accept at edge N → first channel on `sel`/`data` from edge N+1.
- With k enabled channels, SHIFT lasts k·HOLD cycles. `done` is high in the cycle after the last SHIFT cycle. The next accept can occur at the earliest one cycle after `done`.
- With mask 0: accept at edge N → `done` high for cycle N+1 → `in_ready` high again from N+2.
- Throughput for a full mask and HOLD=1: one word per 10 cycles (accept, 8 SHIFT cycles, DONE).
- `sel` and `data` always change on the same edge, so the demux never sees a bit paired with a stale channel.
- Hold counter is 8 bits wide. HOLD=1 means the count never leaves 0.

## Structure
- Shared package `demux_seq_pkg`:
  - `NUM_CH`=8 and `SEL_W`=3.
  - State encoding localparams: IDLE, SHIFT, DONE.
- Sub-module `next_ch_finder`, combinational:
  - Inputs: mask[7:0], start[2:0], include_start.
  - Outputs: found, idx[2:0], giving the lowest enabled index ≥ start (or > start when include_start is 0).
  - Used both for the first-channel search at accept and the next-channel search in SHIFT.
- Top-level: FSM, word/mask registers, hold counter, registered outputs.

## Test plan
- Reset, then `in_word`=8'hA5, `ch_mask`=8'hFF, HOLD=1 → `sel` steps 0..7 on consecutive cycles with `data`=1,0,1,0,0,1,0,1. `done` is high on the 9th cycle after accept.
- `in_word`=8'hFF, `ch_mask`=8'h81, HOLD=3 → `sel`=0 for 3 cycles, then `sel`=7 for 3 cycles, `data`=1 throughout. `done` is high on cycle 7 after accept.
- `ch_mask`=8'h00 → no SHIFT, `data` stays 0, `done` is high in cycle N+1, and `in_ready` is low for exactly that one cycle.
- During SHIFT, change `in_word` and `ch_mask` and hold `in_valid`=1 → output sequence matches the captured values, `in_ready` stays 0, and the new word is accepted only in IDLE after `done`.
- Assert `rst_n`=0 while `sel`=3 → outputs return immediately to their reset values and no `done` pulse occurs. After release, a new accept with 8'h01/8'h01 produces `sel`=0, `data`=1.
- Back-to-back words with `in_valid` held high → accepts are spaced exactly k·HOLD+2 cycles apart.
